// File: rtl/pipeline_control_unit.sv
// Control unit for the 5-stage 16-bit pipeline.
// Decodes the opcode and sequences issue, flush, load-use stall, halt and counters.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            leaves IDLE (ignored elsewhere)
//   opcodeDP[3:0]    opcode held in the decode register
//   enable           PC / decode-register load enable
//   branchC          selects branch target into PC
//   flushC           loads a bubble into the execute register
//   RegWriteC, MemWriteC, MemToRegC, immediateC, alufuncC[1:0]  control word
//   halted           high while in HALT
//   illegal_op       sticky undefined-opcode flag
//   cycle_count      saturating active-cycle counter
//   retired_count    saturating issued-instruction counter
module pipeline_control_unit #(
    parameter int unsigned LOAD_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  opcodeDP,
    output logic        enable,
    output logic        branchC,
    output logic        flushC,
    output logic        RegWriteC,
    output logic        MemWriteC,
    output logic        MemToRegC,
    output logic        immediateC,
    output logic [1:0]  alufuncC,
    output logic        halted,
    output logic        illegal_op,
    output logic [15:0] cycle_count,
    output logic [15:0] retired_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_STALL = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    logic [2:0]  state_q, state_d;
    logic [1:0]  bub_q, bub_d;
    logic        illegal_q, illegal_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ret_q, ret_d;

    logic       dec_rw, dec_mw, dec_m2r, dec_imm, dec_br, dec_legal;
    logic [1:0] dec_alu;
    logic       issue;
    logic       active;

    // Raw opcode decode, independent of pipeline state.
    always_comb begin
        dec_rw    = 1'b0;
        dec_mw    = 1'b0;
        dec_m2r   = 1'b0;
        dec_imm   = 1'b0;
        dec_br    = 1'b0;
        dec_alu   = 2'd0;
        dec_legal = 1'b1;
        case (opcodeDP)
            OP_NOP: ;
            OP_ADD: dec_rw = 1'b1;
            OP_SUB: begin
                dec_rw  = 1'b1;
                dec_alu = 2'd1;
            end
            OP_AND: begin
                dec_rw  = 1'b1;
                dec_alu = 2'd2;
            end
            OP_OR: begin
                dec_rw  = 1'b1;
                dec_alu = 2'd3;
            end
            OP_ADDI: begin
                dec_rw  = 1'b1;
                dec_imm = 1'b1;
            end
            OP_LOAD: begin
                dec_rw  = 1'b1;
                dec_m2r = 1'b1;
                dec_imm = 1'b1;
            end
            OP_STORE: begin
                dec_mw  = 1'b1;
                dec_imm = 1'b1;
            end
            OP_BRANCH: dec_br = 1'b1;
            OP_HALT: ;
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencing FSM; the opcode only matters in RUN.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        enable  = 1'b0;
        flushC  = 1'b1;
        issue   = 1'b0;
        active  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                active = 1'b1;
                if (opcodeDP == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    enable = 1'b1;
                    flushC = 1'b0;
                    issue  = 1'b1;
                    if (dec_br) begin
                        state_d = S_FLUSH;
                    end else if (dec_m2r) begin
                        state_d = S_STALL;
                        bub_d   = 2'(LOAD_BUBBLES);
                    end
                end
            end
            S_FLUSH: begin
                active  = 1'b1;
                enable  = 1'b1;
                state_d = S_RUN;
            end
            S_STALL: begin
                active = 1'b1;
                bub_d  = bub_q - 2'd1;
                // Counter holds the bubbles still owed, this one included.
                if (bub_q <= 2'd1) state_d = S_RUN;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        illegal_d = illegal_q | (issue & ~dec_legal);
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        if (active && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
        if (issue && ret_q != 16'hFFFF)  ret_d = ret_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bub_q     <= 2'd0;
            illegal_q <= 1'b0;
            cyc_q     <= 16'd0;
            ret_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            bub_q     <= bub_d;
            illegal_q <= illegal_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
        end
    end

    assign RegWriteC     = issue & dec_rw;
    assign MemWriteC     = issue & dec_mw;
    assign MemToRegC     = issue & dec_m2r;
    assign immediateC    = issue & dec_imm;
    assign branchC       = issue & dec_br;
    assign alufuncC      = issue ? dec_alu : 2'd0;
    assign halted        = (state_q == S_HALT);
    assign illegal_op    = illegal_q;
    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Sequencing control unit for the 5-stage 16-bit pipeline. Decodes the decode-stage opcode into the per-instruction control word consumed by the datapath: `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`, `alufuncC`, `branchC`. It also owns pipeline sequencing: start/halt, the branch flush, load-use bubbles, and performance counters. It sits directly upstream of the datapath, and its outputs drive the datapath's control inputs one-to-one.

## Interface
- `LOAD_BUBBLES`, default 2: bubble cycles inserted after every LOAD; legal range 1–3.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides all other inputs.
- `start`  in  1  single-cycle pulse; leaves IDLE.
- `opcodeDP`  in  4  opcode of the instruction currently in the decode register.
- `enable`  out  1  PC and decode-register load enable.
- `branchC`  out  1  selects the branch target into the PC.
- `flushC`  out  1  loads a bubble into the execute register.
- `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`  out  1 each  control word bits.
- `alufuncC`  out  2  ALU function.
- `halted`  out  1  high while in HALT.
- `illegal_op`  out  1  sticky; set when an undefined opcode is issued.
- `cycle_count`  out  16  active cycles, saturating.
- `retired_count`  out  16  issued instructions, saturating.

## Operation
- Opcode map:
  - 0x0 NOP.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR: RegWrite=1, alufunc = 0, 1, 2, 3 respectively.
  - 0x5 ADDI: RegWrite=1, immediate=1, alufunc=0.
  - 0x8 LOAD: RegWrite=1, MemToReg=1, immediate=1, alufunc=0.
  - 0x9 STORE: MemWrite=1, immediate=1, alufunc=0.
  - 0xC BRANCH: branch=1, no writes.
  - 0xF HALT.
  - All other codes are illegal: issued as NOP and set `illegal_op`.
- Control word is combinational from `opcodeDP`, gated by state. In any non-issue cycle, all write bits, `immediateC`, `alufuncC` and `branchC` are 0.
- FSM states: IDLE, RUN, FLUSH, STALL, HALT.
- IDLE:
  - Outputs: enable=0, flushC=1.
  - `start` → RUN.
- RUN (the issue state):
  - Outputs: enable=1, flushC=0, control word = decode(`opcodeDP`).
  - BRANCH → FLUSH.
  - LOAD → STALL, bubble counter loaded with `LOAD_BUBBLES`.
  - HALT: not issued; enable=0, flushC=1, → HALT.
  - Otherwise stay in RUN.
- FLUSH:
  - Outputs: enable=1, flushC=1, control word zeroed. This squashes the wrong-path instruction fetched under the branch.
  - → RUN next cycle.
- STALL:
  - Outputs: enable=0, flushC=1.
  - Counter decrements each cycle; → RUN when it reaches 1.
- HALT:
  - Outputs: enable=0, flushC=1, `halted`=1.
  - Exits only via `reset`. `start` is ignored.
- `start` is ignored outside IDLE.
- `retired_count` increments in each RUN cycle whose opcode is not HALT; NOP and illegal opcodes count.
- `cycle_count` increments in every RUN, FLUSH and STALL cycle.
- Both counters saturate at 0xFFFF; no wrap.

## Timing
- Reset values:
  - State IDLE; enable=0, flushC=1.
  - All control bits 0.
  - `halted`=0, `illegal_op`=0, both counters 0.
- Reset asserted mid-operation (any state, including mid-STALL): IDLE on the next edge; counters and `illegal_op` cleared.
- Decode latency is 0 cycles: the control word is valid in the same cycle as `opcodeDP` and is captured by the execute register on that edge.
- Branch:
  - `branchC`=1 for exactly one cycle, the BRANCH issue cycle.
  - Exactly one FLUSH cycle follows.
  - Penalty: 1 cycle.
- LOAD:
  - Issue cycle, then exactly `LOAD_BUBBLES` cycles with enable=0 and flushC=1.
  - The following instruction issues on cycle `LOAD_BUBBLES`+1 after the LOAD issue.
- HALT opcode: `halted` rises on the edge after the HALT decode cycle; `retired_count` is unchanged by the HALT.
- Events that cannot overlap: the opcode is not evaluated in FLUSH or STALL, so a BRANCH or LOAD behind a LOAD waits until RUN.
- `start` coincident with `reset`: reset wins; state stays IDLE.
- Counter updates are registered: visible one cycle after the qualifying cycle.

## Test plan
- Reset then `start`; opcodes ADD, SUB, AND, OR, ADDI on consecutive cycles → RegWrite=1 and alufunc 0,1,2,3,0 in the same cycles; immediateC=1 only for ADDI; `retired_count`=5.
- LOAD with `LOAD_BUBBLES`=2 → issue cycle has MemToRegC=1; next 2 cycles enable=0, flushC=1, all writes 0; the third cycle issues the next opcode; `cycle_count`=3 after these 3 cycles.
- BRANCH → branchC=1 for one cycle; the next cycle has flushC=1, enable=1, control zeroed; the opcode presented during FLUSH (e.g. STORE) is not counted and MemWriteC stays 0.
- Opcode 0x7, then HALT → 0x7 issues as a NOP with `illegal_op`=1; HALT cycle has enable=0, `halted`=1 from the next edge; `start` pulses are ignored; only `reset` returns to IDLE.
- `reset` asserted in the second STALL cycle → next cycle is IDLE with all outputs at reset values. Separately, force `retired_count` to 0xFFFF via 65535+ NOPs → it holds at 0xFFFF.
